// File: rtl/imem_loader_pkg.sv
// Shared types and widths for the instruction-memory loader.
// The checksum state exists only when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_DATA,
        S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Shifts host bytes big-endian into a 32-bit word; last_c flags the byte
// that completes the word and word_c presents the word including that byte.
module imem_loader_byte_assembler
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              shift,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word_c,
    output logic              last_c
);

    // Only the three earlier bytes need storage; the fourth is the live input.
    logic [WORD_W-BYTE_W-1:0] acc;
    logic [1:0]               cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (shift) begin
            acc <= {acc[WORD_W-2*BYTE_W-1:0], byte_in};
            cnt <= cnt + 2'd1;
        end
    end

    assign word_c = {acc, byte_in};
    assign last_c = (cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader: receives a word count then big-endian words, writes them
// to instruction memory and releases the CPU. IMEM_LOADER_CHECKSUM_EN adds an XOR check byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned       MAX_WORDS = 16,
    parameter logic [WORD_W-1:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              initialize,
    output logic [WORD_W-1:0] instruction_initialize_data,
    output logic [WORD_W-1:0] instruction_initialize_address,
    output logic              cpu_rst,
    output logic              done,
    output logic              error
);

    state_t            state, state_next;
    logic [BYTE_W-1:0] n_q, n_next;
    logic [BYTE_W-1:0] idx_q, idx_next;
    logic [BYTE_W-1:0] idx_inc;
    logic [WORD_W-1:0] data_next, addr_next;
    logic              in_ready_next;
    logic              fire;
    logic              asm_clear, asm_shift, asm_last_c;
    logic [WORD_W-1:0] asm_word_c;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum_q, csum_next;
`endif

    assign fire    = in_valid && in_ready;
    assign idx_inc = idx_q + 8'd1;

    imem_loader_byte_assembler u_asm (
        .clk     (clk),
        .rst     (rst),
        .clear   (asm_clear),
        .shift   (asm_shift),
        .byte_in (in_data),
        .word_c  (asm_word_c),
        .last_c  (asm_last_c)
    );

    // Next-state, counters and registered-output next values.
    always_comb begin
        state_next = state;
        n_next     = n_q;
        idx_next   = idx_q;
        data_next  = instruction_initialize_data;
        addr_next  = instruction_initialize_address;
        asm_clear  = 1'b0;
        asm_shift  = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_next  = csum_q;
`endif
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_next = S_COUNT;
                    n_next     = '0;
                    idx_next   = '0;
                    asm_clear  = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_next  = '0;
`endif
                end
            end
            S_COUNT: begin
                if (fire) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_next = csum_q ^ in_data;
`endif
                    if (in_data == '0) begin
                        state_next = S_DONE;
                    end else if (32'(in_data) > MAX_WORDS) begin
                        state_next = S_ERR;
                    end else begin
                        n_next     = in_data;
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (fire) begin
                    asm_shift = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_next = csum_q ^ in_data;
`endif
                    if (asm_last_c) begin
                        state_next = S_WRITE;
                        data_next  = asm_word_c;
                        addr_next  = BASE_ADDR + (32'(idx_q) << 2);
                    end
                end
            end
            S_WRITE: begin
                idx_next = idx_inc;
                if (idx_inc == n_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_next = S_CHECK;
`else
                    state_next = S_DONE;
`endif
                end else begin
                    state_next = S_DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (fire) begin
                    state_next = (in_data == csum_q) ? S_DONE : S_ERR;
                end
            end
`endif
            default: state_next = S_IDLE;
        endcase

        in_ready_next = (state_next == S_COUNT) || (state_next == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                        || (state_next == S_CHECK)
`endif
                        ;
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                          <= S_IDLE;
            n_q                            <= '0;
            idx_q                          <= '0;
            in_ready                       <= 1'b0;
            initialize                     <= 1'b0;
            instruction_initialize_data    <= '0;
            instruction_initialize_address <= '0;
            cpu_rst                        <= 1'b1;
            done                           <= 1'b0;
            error                          <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q                         <= '0;
`endif
        end else begin
            state                          <= state_next;
            n_q                            <= n_next;
            idx_q                          <= idx_next;
            in_ready                       <= in_ready_next;
            initialize                     <= (state_next == S_WRITE);
            instruction_initialize_data    <= data_next;
            instruction_initialize_address <= addr_next;
            cpu_rst                        <= (state_next != S_DONE);
            done                           <= (state_next == S_DONE);
            error                          <= (state_next == S_ERR);
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q                         <= csum_next;
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded bench for imem_loader: expected strobes are queued by the stimulus
// and popped by a monitor; also exercises IMEM_LOADER_CHECKSUM_EN when defined.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start1 = 1'b0;
    logic        start2 = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;

    logic        rdy1, init1, cpu1, done1, err1;
    logic [31:0] data1, addr1;
    logic        rdy2, init2, cpu2, done2, err2;
    logic [31:0] data2, addr2;

    int          n_checks = 0;
    int          n_fail = 0;
    int          sel = 1;
    logic        rdy;
    logic [63:0] q1[$];
    logic [63:0] q2[$];
    logic [63:0] e1, e2;
    logic [7:0]  bq[$];

    always #5 clk = ~clk;

    assign rdy = (sel == 1) ? rdy1 : rdy2;

    imem_loader dut1 (
        .clk                            (clk),
        .rst                            (rst),
        .start                          (start1),
        .in_valid                       (in_valid),
        .in_data                        (in_data),
        .in_ready                       (rdy1),
        .initialize                     (init1),
        .instruction_initialize_data    (data1),
        .instruction_initialize_address (addr1),
        .cpu_rst                        (cpu1),
        .done                           (done1),
        .error                          (err1)
    );

    imem_loader #(.MAX_WORDS(16), .BASE_ADDR(32'hFFFF_FFFC)) dut2 (
        .clk                            (clk),
        .rst                            (rst),
        .start                          (start2),
        .in_valid                       (in_valid),
        .in_data                        (in_data),
        .in_ready                       (rdy2),
        .initialize                     (init2),
        .instruction_initialize_data    (data2),
        .instruction_initialize_address (addr2),
        .cpu_rst                        (cpu2),
        .done                           (done2),
        .error                          (err2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (init1 === 1'b1) begin
                if (q1.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL dut1_unexpected_strobe: got addr %h data %h expected none", addr1, data1);
                end else begin
                    e1 = q1.pop_front();
                    chk("dut1_addr", addr1, e1[63:32]);
                    chk("dut1_data", data1, e1[31:0]);
                end
            end
            if (init2 === 1'b1) begin
                if (q2.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL dut2_unexpected_strobe: got addr %h data %h expected none", addr2, data2);
                end else begin
                    e2 = q2.pop_front();
                    chk("dut2_addr", addr2, e2[63:32]);
                    chk("dut2_data", data2, e2[31:0]);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int k;
        k = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!rdy && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!rdy) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 for byte %h", b);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic send_all();
        for (int i = 0; i < bq.size(); i++) send(bq[i]);
    endtask

    task automatic pulse(input int which);
        @(negedge clk);
        if (which == 1) start1 = 1'b1; else start2 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    initial begin
        // Reset values while rst is held low
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(rdy1), 32'd0);
        chk("rst_initialize", 32'(init1), 32'd0);
        chk("rst_data", data1, 32'h0);
        chk("rst_addr", addr1, 32'h0);
        chk("rst_cpu_rst", 32'(cpu1), 32'd1);
        chk("rst_done", 32'(done1), 32'd0);
        chk("rst_error", 32'(err1), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Two-word load
        q1.push_back({32'h0000_0000, 32'h1234_5678});
        q1.push_back({32'h0000_0004, 32'h9ABC_DEF0});
        pulse(1);
        chk("t1_count_ready", 32'(rdy1), 32'd1);
        chk("t1_busy_cpu_rst", 32'(cpu1), 32'd1);
        bq = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
`ifdef IMEM_LOADER_CHECKSUM_EN
        bq.push_back(8'h02);
`endif
        send_all();
        repeat (3) @(negedge clk);
        chk("t1_done", 32'(done1), 32'd1);
        chk("t1_cpu_rst", 32'(cpu1), 32'd0);
        chk("t1_error", 32'(err1), 32'd0);
        chk("t1_data_hold", data1, 32'h9ABC_DEF0);
        chk("t1_addr_hold", addr1, 32'h0000_0004);

        // Stall between bytes 2 and 3 with an ignored start pulse
        q1.push_back({32'h0000_0000, 32'h1234_5678});
        pulse(1);
        chk("t2_done_cleared", 32'(done1), 32'd0);
        send(8'h01); send(8'h12); send(8'h34);
        pulse(1);
        repeat (3) @(negedge clk);
        chk("t2_still_data", 32'(rdy1), 32'd1);
        send(8'h56); send(8'h78);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h09);
`endif
        repeat (3) @(negedge clk);
        chk("t2_done", 32'(done1), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Bad checksum byte
        q1.push_back({32'h0000_0000, 32'h1234_5678});
        q1.push_back({32'h0000_0004, 32'h9ABC_DEF0});
        pulse(1);
        bq = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h03};
        send_all();
        repeat (3) @(negedge clk);
        chk("t3_error", 32'(err1), 32'd1);
        chk("t3_cpu_rst", 32'(cpu1), 32'd1);
        chk("t3_done", 32'(done1), 32'd0);
`endif

        // Count above MAX_WORDS
        pulse(1);
        send(8'h11);
        repeat (2) @(negedge clk);
        chk("t4_error", 32'(err1), 32'd1);
        chk("t4_cpu_rst", 32'(cpu1), 32'd1);
        chk("t4_done", 32'(done1), 32'd0);
        chk("t4_in_ready", 32'(rdy1), 32'd0);

        // Zero-length program
        pulse(1);
        chk("t5_error_cleared", 32'(err1), 32'd0);
        send(8'h00);
        repeat (2) @(negedge clk);
        chk("t5_done", 32'(done1), 32'd1);
        chk("t5_cpu_rst", 32'(cpu1), 32'd0);
        chk("t5_error", 32'(err1), 32'd0);

        // Reset after two data bytes abandons the word
        pulse(1);
        send(8'h01); send(8'h11); send(8'h22);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_in_ready", 32'(rdy1), 32'd0);
        chk("t6_rst_cpu_rst", 32'(cpu1), 32'd1);
        chk("t6_rst_done", 32'(done1), 32'd0);
        chk("t6_rst_data", data1, 32'h0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_idle_in_ready", 32'(rdy1), 32'd0);
        q1.push_back({32'h0000_0000, 32'hAABB_CCDD});
        pulse(1);
        bq = '{8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
`ifdef IMEM_LOADER_CHECKSUM_EN
        bq.push_back(8'h01);
`endif
        send_all();
        repeat (3) @(negedge clk);
        chk("t6_done", 32'(done1), 32'd1);

        // Address wrap at the top of the 32-bit space
        sel = 2;
        q2.push_back({32'hFFFF_FFFC, 32'h1122_3344});
        q2.push_back({32'h0000_0000, 32'h5566_7788});
        pulse(2);
        bq = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
`ifdef IMEM_LOADER_CHECKSUM_EN
        bq.push_back(8'h8A);
`endif
        send_all();
        repeat (3) @(negedge clk);
        chk("t7_done", 32'(done2), 32'd1);
        chk("t7_cpu_rst", 32'(cpu2), 32'd0);

        repeat (5) @(negedge clk);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q2_drained", 32'(q2.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
